oled_spi_arbiter: RTL and testbench

Shares the single OLED SPI byte writer between two requesters: the power-up init sequencer (port 0) and the pixel/draw engine (port 1). Each requester holds a byte-level start/done handshake; the arbiter grants one at a time, forwards byte and D/C level, enforces an inter-byte gap, and retries stalled transfers via a watchdog. Sits between the requester blocks and the SPI serializer in the OLED top level.

---
 rtl/oled_pkg.sv | 28 ++
 rtl/oled_rr_pick.sv | 42 ++++
 rtl/oled_spi_arbiter.sv | 165 ++++++++++++++++
 tb/tb_oled_spi_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// -----------------------------------------------------------------------------
// oled_pkg
// Shared definitions for the OLED SPI path: arbiter state encoding, D/C level
// constants, default arbiter timing and a small port-select helper.
// -----------------------------------------------------------------------------
package oled_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    // D/C pin levels seen by the panel
    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    // Default arbiter timing
    localparam int unsigned DEF_GAP_CYCLES = 4;
    localparam logic [19:0] DEF_TIMEOUT    = 20'd100000;

    // The port that is not 'port' (two-port arbitration)
    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage

// File: rtl/oled_rr_pick.sv
// -----------------------------------------------------------------------------
// oled_rr_pick
// Combinational winner select between two byte requesters.
//   req0, req1   : pending requests from port 0 / port 1
//   last_grant   : port that received the previous grant
//   grant_valid  : at least one request is pending
//   grant_port   : winning port (meaningful only when grant_valid)
// On a tie, RR_MODE=0 always favours port 0; RR_MODE=1 favours the port
// that did not win last time.
// -----------------------------------------------------------------------------
module oled_rr_pick
    import oled_pkg::*;
#(
    parameter bit RR_MODE = 1'b1
) (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_port
);

    // Winner selection
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = 1'b0;
        if (req0 && req1) begin
            grant_valid = 1'b1;
            grant_port  = RR_MODE ? other_port(last_grant) : 1'b0;
        end else if (req0) begin
            grant_valid = 1'b1;
            grant_port  = 1'b0;
        end else if (req1) begin
            grant_valid = 1'b1;
            grant_port  = 1'b1;
        end else begin
            grant_valid = 1'b0;
            grant_port  = 1'b0;
        end
    end

endmodule

// File: rtl/oled_spi_arbiter.sv
// -----------------------------------------------------------------------------
// oled_spi_arbiter
// Shares one OLED SPI byte writer between the init sequencer (port 0) and the
// draw engine (port 1).
//   CLK, RST_N                    : clock, async active-low reset
//   REQx_START/DATA/DC            : byte request from port x, held until DONE
//   REQx_DONE                     : one-cycle pulse, byte of port x sent
//   SPI_START/DATA/DC, SPI_DONE   : handshake with the serializer
//   OWNER, BUSY                   : granted port, high in WAIT and GAP
//   TIMEOUT_ERR                   : one-cycle pulse when the watchdog aborts
// An aborted transfer produces no DONE; the requester still holds START and
// is simply re-arbitrated after the gap, which acts as an automatic retry.
// -----------------------------------------------------------------------------
module oled_spi_arbiter
    import oled_pkg::*;
#(
    parameter bit          RR_MODE    = 1'b1,
    parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
    parameter logic [19:0] TIMEOUT    = DEF_TIMEOUT
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       REQ0_START,
    input  logic [7:0] REQ0_DATA,
    input  logic       REQ0_DC,
    output logic       REQ0_DONE,
    input  logic       REQ1_START,
    input  logic [7:0] REQ1_DATA,
    input  logic       REQ1_DC,
    output logic       REQ1_DONE,
    output logic       SPI_START,
    output logic [7:0] SPI_DATA,
    output logic       SPI_DC,
    input  logic       SPI_DONE,
    output logic       OWNER,
    output logic       BUSY,
    output logic       TIMEOUT_ERR
);

    // Gap counter counts down to zero, so it is loaded with one less than
    // the number of GAP cycles wanted.
    localparam logic [7:0]  GAP_LOAD     = 8'(GAP_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LAST = TIMEOUT - 20'd1;

    arb_state_t  state_r;
    logic        last_grant_r;
    logic [19:0] wdog_r;
    logic [7:0]  gap_cnt_r;
    logic        spi_start_r;
    logic [7:0]  spi_data_r;
    logic        spi_dc_r;
    logic        owner_r;
    logic        busy_r;
    logic        req0_done_r;
    logic        req1_done_r;
    logic        timeout_err_r;

    logic        grant_valid_s;
    logic        grant_port_s;
    logic [7:0]  grant_data_s;
    logic        grant_dc_s;

    oled_rr_pick #(
        .RR_MODE (RR_MODE)
    ) u_pick (
        .req0        (REQ0_START),
        .req1        (REQ1_START),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant_port  (grant_port_s)
    );

    // Byte and D/C of the winning requester
    always_comb begin
        grant_data_s = REQ0_DATA;
        grant_dc_s   = REQ0_DC;
        if (grant_port_s) begin
            grant_data_s = REQ1_DATA;
            grant_dc_s   = REQ1_DC;
        end else begin
            grant_data_s = REQ0_DATA;
            grant_dc_s   = REQ0_DC;
        end
    end

    // Arbiter FSM with watchdog, gap counter and registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r       <= ST_IDLE;
            last_grant_r  <= 1'b1;
            wdog_r        <= 20'd0;
            gap_cnt_r     <= 8'd0;
            spi_start_r   <= 1'b0;
            spi_data_r    <= 8'h00;
            spi_dc_r      <= DC_CMD;
            owner_r       <= 1'b0;
            busy_r        <= 1'b0;
            req0_done_r   <= 1'b0;
            req1_done_r   <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            // Pulse outputs last a single cycle
            req0_done_r   <= 1'b0;
            req1_done_r   <= 1'b0;
            timeout_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        spi_data_r   <= grant_data_s;
                        spi_dc_r     <= grant_dc_s;
                        spi_start_r  <= 1'b1;
                        owner_r      <= grant_port_s;
                        last_grant_r <= grant_port_s;
                        busy_r       <= 1'b1;
                        wdog_r       <= 20'd0;
                        state_r      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A completion on the timeout cycle still counts as done
                    if (SPI_DONE) begin
                        spi_start_r <= 1'b0;
                        if (owner_r) begin
                            req1_done_r <= 1'b1;
                        end else begin
                            req0_done_r <= 1'b1;
                        end
                        gap_cnt_r <= GAP_LOAD;
                        state_r   <= ST_GAP;
                    end else if (wdog_r == TIMEOUT_LAST) begin
                        spi_start_r   <= 1'b0;
                        timeout_err_r <= 1'b1;
                        gap_cnt_r     <= GAP_LOAD;
                        state_r       <= ST_GAP;
                    end else begin
                        wdog_r <= wdog_r + 20'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == 8'd0) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 8'd1;
                    end
                end
                default: begin
                    spi_start_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign REQ0_DONE   = req0_done_r;
    assign REQ1_DONE   = req1_done_r;
    assign SPI_START   = spi_start_r;
    assign SPI_DATA    = spi_data_r;
    assign SPI_DC      = spi_dc_r;
    assign OWNER       = owner_r;
    assign BUSY        = busy_r;
    assign TIMEOUT_ERR = timeout_err_r;

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// -----------------------------------------------------------------------------
// tb_oled_spi_arbiter
// Two arbiters side by side: index 0 is round-robin with a 4-cycle gap,
// index 1 is fixed priority with a 2-cycle gap; both time out after 50 cycles.
// A transaction-level reference (grant rule, elapsed-cycle counts) predicts
// every output each cycle.
// -----------------------------------------------------------------------------
module tb_oled_spi_arbiter;

    localparam int TO = 50;
    int gap_p[2] = '{4, 2};
    int rr_p[2]  = '{1, 0};

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [1:0] req0_start, req0_dc, req1_start, req1_dc, spi_done;
    logic [7:0] req0_data[2], req1_data[2], spi_data[2];
    logic [1:0] req0_done, req1_done, spi_start, spi_dc, owner, busy, tmo_err;

    always #5 CLK = ~CLK;

    oled_spi_arbiter #(.RR_MODE(1'b1), .GAP_CYCLES(4), .TIMEOUT(20'd50)) u_dut_rr (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0_START(req0_start[0]), .REQ0_DATA(req0_data[0]), .REQ0_DC(req0_dc[0]), .REQ0_DONE(req0_done[0]),
        .REQ1_START(req1_start[0]), .REQ1_DATA(req1_data[0]), .REQ1_DC(req1_dc[0]), .REQ1_DONE(req1_done[0]),
        .SPI_START(spi_start[0]), .SPI_DATA(spi_data[0]), .SPI_DC(spi_dc[0]), .SPI_DONE(spi_done[0]),
        .OWNER(owner[0]), .BUSY(busy[0]), .TIMEOUT_ERR(tmo_err[0]));

    oled_spi_arbiter #(.RR_MODE(1'b0), .GAP_CYCLES(2), .TIMEOUT(20'd50)) u_dut_fp (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0_START(req0_start[1]), .REQ0_DATA(req0_data[1]), .REQ0_DC(req0_dc[1]), .REQ0_DONE(req0_done[1]),
        .REQ1_START(req1_start[1]), .REQ1_DATA(req1_data[1]), .REQ1_DC(req1_dc[1]), .REQ1_DONE(req1_done[1]),
        .SPI_START(spi_start[1]), .SPI_DATA(spi_data[1]), .SPI_DC(spi_dc[1]), .SPI_DONE(spi_done[1]),
        .OWNER(owner[1]), .BUSY(busy[1]), .TIMEOUT_ERR(tmo_err[1]));

    // Reference state: phase 0 idle, 1 transfer, 2 gap
    int         m_st[2], m_wn[2], m_gl[2], m_tgt[2];
    logic       m_last[2];
    logic       x_start[2], x_dc[2], x_owner[2], x_busy[2], x_d0[2], x_d1[2], x_err[2];
    logic [7:0] x_data[2];

    int         checks = 0;
    int         errors = 0;
    int         mode;
    logic [7:0] init_seq[9] = '{8'hAE, 8'h81, 8'hFF, 8'h82, 8'hFF, 8'h83, 8'hFF, 8'h87, 8'h06};
    int         init_idx[2];
    logic [7:0] ser_log[2][$];
    int         grant_log[2][$];
    int         done0_cnt[2], busy_cnt[2];
    logic       prev_start[2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_st[i] = 0; m_wn[i] = 0; m_gl[i] = 0; m_tgt[i] = 0; m_last[i] = 1'b1;
        x_start[i] = 0; x_dc[i] = 0; x_owner[i] = 0; x_busy[i] = 0;
        x_d0[i] = 0; x_d1[i] = 0; x_err[i] = 0; x_data[i] = 8'h00;
    endtask

    // Serializer latency for the next transfer: 0 means it never answers
    function automatic int pick_target();
        int r;
        if (mode == 0) return 10;
        if (mode == 2) return $urandom_range(1, 8);
        r = $urandom % 8;
        if (r == 0) return 0;
        if (r == 1) return TO;
        return $urandom_range(1, 12);
    endfunction

    // Predict the effect of the coming clock edge
    task automatic model_step(input int i);
        logic p;
        if (RST_N == 1'b0) begin
            model_reset(i);
            return;
        end
        x_d0[i] = 0; x_d1[i] = 0; x_err[i] = 0;
        if (m_st[i] == 0) begin
            if (req0_start[i] || req1_start[i]) begin
                if (req0_start[i] && req1_start[i])
                    p = (rr_p[i] == 1) ? !m_last[i] : 1'b0;
                else
                    p = !req0_start[i];
                x_start[i] = 1; x_busy[i] = 1; x_owner[i] = p; m_last[i] = p;
                x_data[i]  = p ? req1_data[i] : req0_data[i];
                x_dc[i]    = p ? req1_dc[i] : req0_dc[i];
                m_wn[i] = 0; m_tgt[i] = pick_target(); m_st[i] = 1;
            end
        end else if (m_st[i] == 1) begin
            m_wn[i]++;
            if (spi_done[i]) begin
                x_start[i] = 0;
                if (x_owner[i]) x_d1[i] = 1; else x_d0[i] = 1;
                m_gl[i] = gap_p[i]; m_st[i] = 2;
            end else if (m_wn[i] == TO) begin
                x_start[i] = 0; x_err[i] = 1;
                m_gl[i] = gap_p[i]; m_st[i] = 2;
            end
        end else begin
            m_gl[i]--;
            if (m_gl[i] == 0) begin
                m_st[i] = 0; x_busy[i] = 0;
            end
        end
    endtask

    // Requester behaviour: hold START until DONE, then drop it
    task automatic drive_reqs(input int i);
        for (int p = 0; p < 2; p++) begin
            logic st, dn, own_w, up, c;
            logic [7:0] d;
            st    = (p == 1) ? req1_start[i] : req0_start[i];
            dn    = (p == 1) ? x_d1[i] : x_d0[i];
            own_w = (m_st[i] == 1) && (x_owner[i] == (p == 1));
            up = 0; d = 8'($urandom); c = 1'($urandom);
            if (mode == 0) begin
                if (p == 0) begin
                    if (st && dn) st = 0;
                    else if (!st && init_idx[i] < 9) begin
                        st = 1; up = 1; d = init_seq[init_idx[i]]; c = 1'b0; init_idx[i]++;
                    end
                end
            end else if (mode == 1) begin
                if (st && dn) st = 0;
                else if (st && own_w && ($urandom % 16 == 0)) st = 0;
                else if (!st && !own_w && ($urandom % 3 == 0)) begin st = 1; up = 1; end
            end else begin
                if (st && dn) st = 0;
                else if (!st) begin st = 1; up = 1; end
            end
            if (p == 1) begin
                req1_start[i] = st;
                if (up) begin req1_data[i] = d; req1_dc[i] = c; end
            end else begin
                req0_start[i] = st;
                if (up) begin req0_data[i] = d; req0_dc[i] = c; end
            end
        end
    endtask

    task automatic cycle(input logic rst_val);
        logic [31:0] got_v, exp_v;
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            got_v = {17'd0, spi_start[i], spi_dc[i], (x_busy[i] ? owner[i] : 1'b0), busy[i],
                     req0_done[i], req1_done[i], tmo_err[i], spi_data[i]};
            exp_v = {17'd0, x_start[i], x_dc[i], (x_busy[i] ? x_owner[i] : 1'b0), x_busy[i],
                     x_d0[i], x_d1[i], x_err[i], x_data[i]};
            check_val($sformatf("outs%0d", i), got_v, exp_v);
            if (req0_done[i]) done0_cnt[i]++;
            if (busy[i]) busy_cnt[i]++;
            if (spi_start[i] && !prev_start[i]) grant_log[i].push_back(int'(owner[i]));
            prev_start[i] = spi_start[i];
        end
        RST_N = rst_val;
        for (int i = 0; i < 2; i++) begin
            drive_reqs(i);
            spi_done[i] = 1'b0;
            if (m_st[i] == 1 && m_tgt[i] != 0 && m_wn[i] + 1 == m_tgt[i]) spi_done[i] = 1'b1;
            else if (mode == 1 && m_st[i] != 1 && ($urandom % 8 == 0)) spi_done[i] = 1'b1;
            if (spi_done[i] && spi_start[i]) ser_log[i].push_back(spi_data[i]);
            model_step(i);
        end
    endtask

    initial begin
        req0_start = '0; req1_start = '0; req0_dc = '0; req1_dc = '0; spi_done = '0;
        for (int i = 0; i < 2; i++) begin
            req0_data[i] = 8'h00; req1_data[i] = 8'h00;
            init_idx[i] = 0; done0_cnt[i] = 0; busy_cnt[i] = 0; prev_start[i] = 1'b0;
            model_reset(i);
        end

        // Reset values, then the init sequence on port 0 with a 10-cycle serializer
        mode = 0;
        repeat (3) cycle(1'b0);
        for (int i = 0; i < 2; i++) begin
            busy_cnt[i] = 0; done0_cnt[i] = 0; ser_log[i].delete();
        end
        repeat (300) cycle(1'b1);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("init_bytes%0d", i), ser_log[i].size(), 9);
            for (int k = 0; k < 9; k++)
                check_val($sformatf("init_byte%0d_%0d", i, k),
                          (k < ser_log[i].size()) ? {24'd0, ser_log[i][k]} : 32'hFFFF_FFFF,
                          {24'd0, init_seq[k]});
            check_val($sformatf("init_done%0d", i), done0_cnt[i], 9);
            check_val($sformatf("init_busy%0d", i), busy_cnt[i], 9 * (10 + gap_p[i]));
        end

        // Random traffic: timeouts, done on the timeout cycle, stray SPI_DONE
        mode = 1;
        repeat (3000) cycle(1'b1);

        // Asynchronous reset in the middle of a transfer
        for (int k = 0; k < 200 && m_st[0] != 1; k++) cycle(1'b1);
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1 check_val("async_rst",
                     {18'd0, spi_start, spi_dc, owner, busy, req0_done, req1_done, tmo_err},
                     32'd0);
        check_val("async_rst_data", {16'd0, spi_data[0], spi_data[1]}, 32'd0);
        model_reset(0);
        model_reset(1);

        // Both ports request continuously after release
        mode = 2;
        repeat (2) cycle(1'b0);
        grant_log[0].delete();
        grant_log[1].delete();
        repeat (200) cycle(1'b1);
        for (int i = 0; i < 2; i++)
            check_val($sformatf("tie_grants%0d", i), 32'(grant_log[i].size() >= 6), 32'd1);
        for (int k = 0; k < 6; k++) begin
            check_val($sformatf("rr_order_%0d", k),
                      (k < grant_log[0].size()) ? grant_log[0][k] : -1, k % 2);
            check_val($sformatf("fp_order_%0d", k),
                      (k < grant_log[1].size()) ? grant_log[1][k] : -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
